// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic units.
//
// Handshake common to every unit:
//   start - one-cycle request. A unit accepts it only when idle (IDLE) or
//           holding a finished result (DONE). Operands are sampled with it.
//   ready - result valid. Stays high until the next accepted start or reset.
//   busy  - high while the unit is computing (RUN and FIX).
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } calc_state_t;

    // Width of a counter that indexes bits 0..w-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int w);
        int n;
        n = $clog2(w);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/seq_multiplier_param.sv
// Parametrised shift-and-add sequential multiplier for the calculator
// datapath. Processes one multiplier bit per cycle, LSB first. Signed
// operands are reduced to magnitudes and the sign is applied in FIX.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   request, accepted in IDLE or DONE
//   signed_mode  in   1 = two's-complement operands (sampled with start)
//   num1         in   multiplicand, WIDTH bits (sampled with start)
//   num2         in   multiplier, WIDTH bits (sampled with start)
//   result       out  2*WIDTH-bit product, stable while ready=1
//   ready        out  result valid until next accepted start or rst
//   busy         out  high in RUN and FIX
//
// state | meaning
// IDLE  | waiting for the first start after reset
// RUN   | one multiplier bit per cycle, accumulating partial products
// FIX   | apply sign to accumulator, publish result
// DONE  | result held with ready=1; start re-arms as from IDLE
import calc_pkg::*;

module seq_multiplier_param #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     num1,
    input  logic [WIDTH-1:0]     num2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    calc_state_t         r_state;
    calc_state_t         w_next;

    logic [PW-1:0]       r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [CW-1:0]       r_cnt;
    logic [PW-1:0]       r_acc;
    logic                r_neg;
    logic [PW-1:0]       r_result;
    logic                r_ready;

    logic [WIDTH-1:0]    w_mag1;
    logic [WIDTH-1:0]    w_mag2;
    logic                w_neg;
    logic                w_accept;
    logic [WIDTH-1:0]    w_mplier_next;
    logic                w_run_last;

    // -2^(WIDTH-1) negates to itself, which read as unsigned is its magnitude.
    assign w_mag1 = (signed_mode && num1[WIDTH-1]) ? -num1 : num1;
    assign w_mag2 = (signed_mode && num2[WIDTH-1]) ? -num2 : num2;
    assign w_neg  = signed_mode & (num1[WIDTH-1] ^ num2[WIDTH-1]);

    assign w_accept      = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_mplier_next = r_mplier >> 1;
    assign w_run_last    = (r_cnt == LAST_BIT) ||
                           (EARLY_EXIT && (w_mplier_next == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next = (EARLY_EXIT && (w_mag2 == '0)) ? FIX : RUN;
                end
            end
            RUN: begin
                if (w_run_last) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                w_next = DONE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_neg    <= w_neg;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else if (r_state == RUN) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + (r_mcand << r_cnt);
            end
            r_mplier <= w_mplier_next;
            r_cnt    <= r_cnt + 1'b1;
        end else if (r_state == FIX) begin
            r_result <= r_neg ? -r_acc : r_acc;
            r_ready  <= 1'b1;
        end
    end

    assign result = r_result;
    assign ready  = r_ready;
    assign busy   = (r_state == RUN) || (r_state == FIX);

endmodule

// File: doc/seq_multiplier_param.md
Name: seq_multiplier_param

Overview:
- Parametrised shift-and-add sequential multiplier. Next generation of the calculator datapath's iterative multiplier.
- Latency is bounded by operand width rather than operand value.
- Adds a run-time signed/unsigned mode, optional early termination, and a busy flag.
- Sits between the calculator's operand registers and its result mux, using the same start/ready handshake as the other arithmetic units.

Parameters:
- WIDTH, 16: operand width in bits (≥2); result is 2*WIDTH bits.
- EARLY_EXIT, 0: 1 = stop iterating once the remaining multiplier bits are all zero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE or DONE.
- signed_mode  in  1  1 = two's-complement operands; sampled with start.
- num1  in  WIDTH  multiplicand; sampled with start.
- num2  in  WIDTH  multiplier; sampled with start.
- result  out  2*WIDTH  product; held stable while ready=1.
- ready  out  1  result valid; stays high until the next accepted start or rst.
- busy  out  1  high in RUN and FIX.

Behaviour:
- Reset: on an edge with rst=1, state goes to IDLE and result=0, ready=0, busy=0. rst has priority over everything, including a transaction in flight, which is abandoned.
- States: IDLE, RUN, FIX, DONE.
- Accept: start=1 in IDLE or DONE at edge k:
  - latch operands and mode;
  - ready<=0, result<=0, busy<=1;
  - acc<=0, bit counter<=0;
  - next state RUN, or FIX if EARLY_EXIT=1 and the multiplier magnitude is 0.
- Ignore: start in RUN or FIX has no effect. Operand and mode changes after accept have no effect.
- Operand prep:
  - signed_mode=1: use the magnitudes of both operands; neg flag = sign(num1) XOR sign(num2).
  - -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits, so no overflow case exists.
  - signed_mode=0: use operands as-is; neg=0.
- RUN, one cycle per multiplier bit, LSB first:
  - if the current bit is 1, acc += multiplicand shifted left by the counter value;
  - shift the multiplier right and increment the counter;
  - all arithmetic in 2*WIDTH bits; the product never overflows.
- RUN exit to FIX (no extra cycle) when the counter has processed bit WIDTH-1, or when EARLY_EXIT=1 and the shifted multiplier is 0.
- FIX: result <= neg ? -acc : acc (2*WIDTH-bit two's complement); ready<=1; busy<=0; next state DONE.
- DONE: hold result and ready; start re-arms exactly as from IDLE.
- Latency, from accept edge k to the edge that sets ready:
  - EARLY_EXIT=0: WIDTH+1 cycles, independent of data.
  - EARLY_EXIT=1: h+2 cycles, where h is the index of the highest set bit of the multiplier magnitude; 1 cycle when the multiplier is 0.
- Zero multiplicand: no special case; iterates normally and produces 0. A negative sign applied to 0 still gives 0.
- Back-to-back: start=1 in the same cycle ready is observed high is accepted. ready drops on the next edge.

Decomposition:
- Shared package calc_pkg:
  - state enum {IDLE, RUN, FIX, DONE};
  - clog2-based counter-width function;
  - the handshake convention (start/ready/busy) common to all calculator arithmetic units.
- No sub-module needed. An optional abs_neg helper (magnitude/negate, WIDTH-parametrised) may live in calc_pkg as a function.

Test Plan:
- WIDTH=16, EARLY_EXIT=0, unsigned, 1234*567 -> result=0x000AAD1E, ready high exactly 17 cycles after the accept edge, busy high for those 17 cycles.
- Signed, num1=0xFFFD (-3), num2=0x0005 -> 0xFFFFFFF1. Signed 0xFFFF*0xFFFF -> 0x00000001. Unsigned 0xFFFF*0xFFFF -> 0xFFFE0001.
- Signed 0x8000*0x8000 -> 0x40000000. Signed 0x8000*0x0001 -> 0xFFFF8000.
- EARLY_EXIT=1, unsigned, 7*2 -> result=14 after 3 cycles. 7*0 -> result=0 after 1 cycle. 7*0x8000 -> result=0x00038000 after 17 cycles.
- start pulsed at cycle 5 of RUN with new operands -> ignored, original product delivered on schedule. start while ready=1 -> ready drops next edge, new result delivered.
- rst asserted mid-RUN -> next edge IDLE with result=0, ready=0, busy=0. Subsequent start computes a fresh, correct product.
